// File: rtl/regfile_write_arbiter_pkg.sv
// Shared CPU regfile constants, the writeback request record and small
// helpers used by the regfile write arbiter and its result FIFO.
package regfile_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // One-hot decode of a register index into a busy-mask sized vector.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        reg_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << r;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of writeback, multi-cycle result and regfile-port signals around
// the write arbiter; master is the surrounding pipeline, slave the arbiter.
interface regfile_write_arbiter_if;
    import regfile_write_arbiter_pkg::*;

    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic                  md_valid;
    logic [REG_ADDR_W-1:0] md_rd;
    logic [XLEN-1:0]       md_data;
    logic                  md_ready;
    logic                  md_issue;
    logic [REG_ADDR_W-1:0] md_issue_rd;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       reg_in;
    logic [NUM_REGS-1:0]   busy_mask;
    logic                  starve_req;
    logic                  waw_err;

    modport master (
        output wb_we, wb_rd, wb_data, md_valid, md_rd, md_data, md_issue, md_issue_rd,
        input  md_ready, reg_write, rd, reg_in, busy_mask, starve_req, waw_err
    );

    modport slave (
        input  wb_we, wb_rd, wb_data, md_valid, md_rd, md_data, md_issue, md_issue_rd,
        output md_ready, reg_write, rd, reg_in, busy_mask, starve_req, waw_err
    );

endinterface

// File: rtl/regfile_write_arbiter_fifo.sv
// Circular buffer holding multi-cycle results ({rd, data}) until the
// arbiter finds a free regfile write slot.
module wb_result_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [REG_ADDR_W-1:0] push_rd,
    input  logic [XLEN-1:0]       push_data,
    input  logic                  pop,
    output logic [REG_ADDR_W-1:0] head_rd,
    output logic [XLEN-1:0]       head_data,
    output logic [CNT_W-1:0]      count
);

    logic [REG_ADDR_W-1:0] rd_mem_r   [DEPTH];
    logic [XLEN-1:0]       data_mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        next_ptr = (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
    endfunction

    assign push_ok_s = push && (count_r < CNT_W'(DEPTH));
    assign pop_ok_s  = pop && (count_r != CNT_W'(0));
    assign head_rd   = rd_mem_r[rd_ptr_r];
    assign head_data = data_mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy; simultaneous push/pop keeps count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_r[i]   <= '0;
                data_mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                rd_mem_r[wr_ptr_r]   <= push_rd;
                data_mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r             <= next_ptr(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single regfile write port shared by pipeline writeback (priority) and
// buffered mul/div results; tracks pending destinations and starvation.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_write_arbiter_if.slave bus
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]      fifo_count_s;
    logic [REG_ADDR_W-1:0] head_rd_s;
    logic [XLEN-1:0]       head_data_s;
    logic                  fifo_empty_s;
    logic                  wb_valid_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  reg_write_nx_s;
    logic [REG_ADDR_W-1:0] rd_nx_s;
    logic [XLEN-1:0]       reg_in_nx_s;
    logic [NUM_REGS-1:0]   set_s;
    logic [NUM_REGS-1:0]   clr_s;
    logic [NUM_REGS-1:0]   busy_nx_s;
    logic [WAIT_W-1:0]     wait_nx_s;
    logic                  waw_nx_s;

    logic                  reg_write_r;
    logic [REG_ADDR_W-1:0] rd_r;
    logic [XLEN-1:0]       reg_in_r;
    logic [NUM_REGS-1:0]   busy_r;
    logic [WAIT_W-1:0]     wait_r;
    logic                  starve_r;
    logic                  waw_r;

    // A writeback to x0 is not a request, so it never blocks a FIFO pop.
    assign wb_valid_s   = bus.wb_we && (bus.wb_rd != REG_ADDR_W'(0));
    assign fifo_empty_s = (fifo_count_s == CNT_W'(0));
    assign bus.md_ready = (fifo_count_s < CNT_W'(FIFO_DEPTH));
    assign push_s       = bus.md_valid && bus.md_ready;

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_rd   (bus.md_rd),
        .push_data (bus.md_data),
        .pop       (pop_s),
        .head_rd   (head_rd_s),
        .head_data (head_data_s),
        .count     (fifo_count_s)
    );

    // Write-port arbitration: pipeline first, then FIFO head, else idle.
    always_comb begin
        reg_write_nx_s = 1'b0;
        rd_nx_s        = rd_r;
        reg_in_nx_s    = reg_in_r;
        pop_s          = 1'b0;
        if (wb_valid_s) begin
            reg_write_nx_s = 1'b1;
            rd_nx_s        = bus.wb_rd;
            reg_in_nx_s    = bus.wb_data;
        end else if (!fifo_empty_s) begin
            pop_s          = 1'b1;
            reg_write_nx_s = (head_rd_s != REG_ADDR_W'(0));
            rd_nx_s        = head_rd_s;
            reg_in_nx_s    = head_data_s;
        end else begin
            pop_s          = 1'b0;
        end
    end

    // Pending-result scoreboard (set beats clear), head wait counter, WAW flag.
    always_comb begin
        set_s     = bus.md_issue ? reg_onehot(bus.md_issue_rd) : NUM_REGS'(0);
        clr_s     = pop_s ? reg_onehot(head_rd_s) : NUM_REGS'(0);
        busy_nx_s = ((busy_r & ~clr_s) | set_s) & ~NUM_REGS'(1);
        wait_nx_s = wait_r;
        if (fifo_empty_s || pop_s) begin
            wait_nx_s = WAIT_W'(0);
        end else if (wait_r < WAIT_W'(STARVE_LIMIT)) begin
            wait_nx_s = wait_r + WAIT_W'(1);
        end else begin
            wait_nx_s = wait_r;
        end
        waw_nx_s = waw_r | (wb_valid_s & busy_r[bus.wb_rd]);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_r <= 1'b0;
            rd_r        <= '0;
            reg_in_r    <= '0;
            busy_r      <= '0;
            wait_r      <= '0;
            starve_r    <= 1'b0;
            waw_r       <= 1'b0;
        end else begin
            reg_write_r <= reg_write_nx_s;
            rd_r        <= rd_nx_s;
            reg_in_r    <= reg_in_nx_s;
            busy_r      <= busy_nx_s;
            wait_r      <= wait_nx_s;
            starve_r    <= (wait_nx_s == WAIT_W'(STARVE_LIMIT));
            waw_r       <= waw_nx_s;
        end
    end

    assign bus.reg_write  = reg_write_r;
    assign bus.rd         = rd_r;
    assign bus.reg_in     = reg_in_r;
    assign bus.busy_mask  = busy_r;
    assign bus.starve_req = starve_r;
    assign bus.waw_err    = waw_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scenario-driven bench: expected regfile writes are queued as stimulus is
// applied and matched against the write port as the DUT produces them.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    wb_req_t sb[$];

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(.STARVE_LIMIT(4), .FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and match any regfile write against the scoreboard.
    task automatic advance();
        wb_req_t e;
        @(posedge clk);
        #1;
        if (bus.reg_write === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got rd=%0d data=%h want no write", bus.rd, bus.reg_in);
            end else begin
                e = sb.pop_front();
                if (bus.rd !== e.rd || bus.reg_in !== e.data) begin
                    errors++;
                    $display("FAIL write_order: got rd=%0d data=%h want rd=%0d data=%h",
                             bus.rd, bus.reg_in, e.rd, e.data);
                end
            end
        end
    endtask

    task automatic expect_push(input logic [4:0] r, input logic [31:0] d);
        wb_req_t e;
        e.we = 1'b1; e.rd = r; e.data = d;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'h0;
        bus.md_valid = 1'b0; bus.md_rd = 5'd0; bus.md_data = 32'h0;
        bus.md_issue = 1'b0; bus.md_issue_rd = 5'd0;
        #12;
        checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %b want 0", bus.reg_write); end
        checks++; if (bus.rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", bus.rd); end
        checks++; if (bus.reg_in !== 32'h0) begin errors++; $display("FAIL reset_reg_in: got %h want 0", bus.reg_in); end
        checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL reset_md_ready: got %b want 1", bus.md_ready); end
        checks++; if (bus.busy_mask !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", bus.busy_mask); end
        checks++; if (bus.starve_req !== 1'b0) begin errors++; $display("FAIL reset_starve: got %b want 0", bus.starve_req); end
        checks++; if (bus.waw_err !== 1'b0) begin errors++; $display("FAIL reset_waw: got %b want 0", bus.waw_err); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_wb_write();
        bus.wb_we = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
        expect_push(5'd5, 32'hDEADBEEF);
        advance();
        checks++; if (bus.reg_write !== 1'b1) begin errors++; $display("FAIL wb_latency: got %b want 1", bus.reg_write); end
        bus.wb_we = 1'b0;
        advance();
        checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL wb_deassert: got %b want 0", bus.reg_write); end
        checks++; if (bus.rd !== 5'd5 || bus.reg_in !== 32'hDEADBEEF) begin errors++; $display("FAIL wb_hold: got rd=%0d data=%h want rd=5 data=deadbeef", bus.rd, bus.reg_in); end
    endtask

    task automatic test_md_result();
        bus.md_issue = 1'b1; bus.md_issue_rd = 5'd7;
        advance();
        checks++; if (bus.busy_mask !== 32'h80) begin errors++; $display("FAIL md_busy_set: got %h want 00000080", bus.busy_mask); end
        bus.md_issue = 1'b0;
        advance();
        bus.md_valid = 1'b1; bus.md_rd = 5'd7; bus.md_data = 32'h12;
        expect_push(5'd7, 32'h12);
        advance();
        bus.md_valid = 1'b0;
        checks++; if (bus.reg_write !== 1'b0 || bus.busy_mask !== 32'h80) begin errors++; $display("FAIL md_latency: got we=%b busy=%h want we=0 busy=00000080", bus.reg_write, bus.busy_mask); end
        advance();
        checks++; if (bus.reg_write !== 1'b1 || bus.busy_mask !== 32'h0) begin errors++; $display("FAIL md_write_clear: got we=%b busy=%h want we=1 busy=0", bus.reg_write, bus.busy_mask); end
    endtask

    task automatic test_starve();
        bus.wb_we = 1'b1; bus.wb_rd = 5'd3;
        for (int i = 0; i < 6; i++) begin
            bus.wb_data = 32'h3000_0000 + 32'(i);
            expect_push(5'd3, 32'h3000_0000 + 32'(i));
            bus.md_valid = (i < 2);
            bus.md_rd    = (i == 0) ? 5'd10 : 5'd11;
            bus.md_data  = (i == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002;
            advance();
            if (i == 1) begin
                checks++; if (bus.md_ready !== 1'b0) begin errors++; $display("FAIL starve_full: got %b want 0", bus.md_ready); end
            end
            if (i == 3) begin
                checks++; if (bus.starve_req !== 1'b0) begin errors++; $display("FAIL starve_early: got %b want 0", bus.starve_req); end
            end
            if (i >= 4) begin
                checks++; if (bus.starve_req !== 1'b1) begin errors++; $display("FAIL starve_assert: got %b want 1 (iter %0d)", bus.starve_req, i); end
            end
        end
        bus.md_valid = 1'b0;
        bus.wb_we = 1'b0;
        expect_push(5'd10, 32'hAAAA_0001);
        expect_push(5'd11, 32'hBBBB_0002);
        advance();
        checks++; if (bus.starve_req !== 1'b0 || bus.md_ready !== 1'b1) begin errors++; $display("FAIL starve_release: got starve=%b ready=%b want 0/1", bus.starve_req, bus.md_ready); end
        advance();
        advance();
        checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL starve_drain: got %b want 0", bus.reg_write); end
    endtask

    task automatic test_push_pop();
        bus.md_valid = 1'b1; bus.md_rd = 5'd12; bus.md_data = 32'hC0C0_0012;
        expect_push(5'd12, 32'hC0C0_0012);
        advance();
        bus.md_rd = 5'd13; bus.md_data = 32'hD0D0_0013;
        expect_push(5'd13, 32'hD0D0_0013);
        advance();
        checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL pushpop_ready: got %b want 1", bus.md_ready); end
        bus.md_valid = 1'b0;
        advance();
        checks++; if (bus.reg_write !== 1'b1 || bus.md_ready !== 1'b1) begin errors++; $display("FAIL pushpop_second: got we=%b ready=%b want 1/1", bus.reg_write, bus.md_ready); end
        advance();
        checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL pushpop_empty: got %b want 0", bus.reg_write); end
    endtask

    task automatic test_waw();
        bus.md_issue = 1'b1; bus.md_issue_rd = 5'd9;
        advance();
        checks++; if (bus.busy_mask !== 32'h200 || bus.waw_err !== 1'b0) begin errors++; $display("FAIL waw_pre: got busy=%h waw=%b want 00000200/0", bus.busy_mask, bus.waw_err); end
        bus.md_issue = 1'b0;
        bus.wb_we = 1'b1; bus.wb_rd = 5'd9; bus.wb_data = 32'hE000_0009;
        expect_push(5'd9, 32'hE000_0009);
        advance();
        checks++; if (bus.waw_err !== 1'b1) begin errors++; $display("FAIL waw_set: got %b want 1", bus.waw_err); end
        bus.wb_rd = 5'd0; bus.wb_data = 32'hFFFF_FFFF;
        bus.md_valid = 1'b1; bus.md_rd = 5'd9; bus.md_data = 32'h6000_0009;
        advance();
        checks++; if (bus.reg_write !== 1'b0) begin errors++; $display("FAIL wb_x0_write: got %b want 0", bus.reg_write); end
        bus.md_valid = 1'b0;
        expect_push(5'd9, 32'h6000_0009);
        advance();
        checks++; if (bus.busy_mask !== 32'h0 || bus.reg_write !== 1'b1) begin errors++; $display("FAIL wb_x0_pop: got busy=%h we=%b want 0/1", bus.busy_mask, bus.reg_write); end
        bus.wb_we = 1'b0;
        advance();
        advance();
        checks++; if (bus.waw_err !== 1'b1) begin errors++; $display("FAIL waw_sticky: got %b want 1", bus.waw_err); end
    endtask

    task automatic test_reset_mid();
        bus.wb_we = 1'b1; bus.wb_rd = 5'd1;
        for (int i = 0; i < 3; i++) begin
            bus.wb_data     = 32'h1000_0000 + 32'(i);
            expect_push(5'd1, 32'h1000_0000 + 32'(i));
            bus.md_issue    = (i < 2);
            bus.md_issue_rd = (i == 0) ? 5'd7 : 5'd8;
            bus.md_valid    = (i > 0);
            bus.md_rd       = (i == 1) ? 5'd7 : 5'd8;
            bus.md_data     = 32'h7700_0000 + 32'(i);
            advance();
        end
        bus.md_issue = 1'b0; bus.md_valid = 1'b0; bus.wb_we = 1'b0;
        checks++; if (bus.md_ready !== 1'b0 || bus.busy_mask !== 32'h180) begin errors++; $display("FAIL mid_prestate: got ready=%b busy=%h want 0/00000180", bus.md_ready, bus.busy_mask); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.reg_write !== 1'b0 || bus.rd !== 5'd0 || bus.reg_in !== 32'h0) begin errors++; $display("FAIL mid_port: got we=%b rd=%0d data=%h want 0/0/0", bus.reg_write, bus.rd, bus.reg_in); end
        checks++; if (bus.busy_mask !== 32'h0 || bus.md_ready !== 1'b1) begin errors++; $display("FAIL mid_fifo: got busy=%h ready=%b want 0/1", bus.busy_mask, bus.md_ready); end
        checks++; if (bus.waw_err !== 1'b0 || bus.starve_req !== 1'b0) begin errors++; $display("FAIL mid_flags: got waw=%b starve=%b want 0/0", bus.waw_err, bus.starve_req); end
        advance();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            advance();
            checks++; if (bus.reg_write !== 1'b0 || bus.md_ready !== 1'b1) begin errors++; $display("FAIL mid_discard: got we=%b ready=%b want 0/1", bus.reg_write, bus.md_ready); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_wb_write();
        test_md_result();
        test_starve();
        test_push_pop();
        test_waw();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_writes: got %0d outstanding want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive lost cycles of a FIFO head before starve_req asserts.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of buffered multi-cycle results.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wb_we, wb_rd, wb_data  input  1/5/32  pipeline writeback request; it has no backpressure.
REQ-006 md_valid, md_rd, md_data  input  1/5/32  multi-cycle (mul/div) result offer.
REQ-007 md_ready  output  1  result FIFO can accept this cycle.
REQ-008 md_issue, md_issue_rd  input  1/5  mul/div operation started; it reserves the destination register.
REQ-009 reg_write, rd, reg_in  output  1/5/32  registered regfile write port; the regfile consumes it on the following negedge.
REQ-010 busy_mask  output  32  per-register pending-result scoreboard for the hazard unit.
REQ-011 starve_req  output  1  request to the hazard unit to suppress wb_we for one cycle.
REQ-012 waw_err  output  1  sticky flag: pipeline wrote a register with a pending result.

Function
REQ-013 Arbitration at each posedge SHALL follow this priority.
- wb_we=1 and wb_rd!=0: drive {1, wb_rd, wb_data}.
- Otherwise, FIFO non-empty: drive {head_rd!=0, head_rd, head_data} and pop.
- Otherwise: drive reg_write=0, with rd/reg_in holding their last values.
REQ-014 wb_we=1 with wb_rd=0 SHALL be treated as no request, so the FIFO may pop in that cycle.
REQ-015 Latency SHALL be as follows.
- Pipeline request sampled at edge k: reg_write is high from edge k to k+1.
- md handshake at edge k with no competing wb: reg_write is high from edge k+1 to k+2.
REQ-016 md_ready SHALL equal (count < FIFO_DEPTH), decoded from registered count, with no same-cycle pop bypass.
REQ-017 Push SHALL occur when md_valid && md_ready; simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-018 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-019 An entry with head_rd=0 SHALL be popped using one arbitration slot, with reg_write=0.
REQ-020 busy_mask[r] SHALL set at the edge where md_issue=1 and md_issue_rd=r!=0, and clear at the edge where an entry with rd=r pops.
REQ-021 When set and clear of the same bit coincide, set SHALL win; busy_mask[0] SHALL always be 0.
REQ-022 The wait counter SHALL increment (saturating at STARVE_LIMIT) at each edge where the FIFO is non-empty and the head is not popped, and SHALL clear on pop or when the FIFO is empty.
REQ-023 starve_req SHALL be high while the wait counter == STARVE_LIMIT.
REQ-024 If wb_we remains high despite starve_req, the arbiter SHALL still give priority to wb; the suppression is the hazard unit's responsibility.
REQ-025 waw_err SHALL set at an edge where wb_we=1, wb_rd!=0 and busy_mask[wb_rd]=1, and SHALL clear only on reset.
REQ-026 The arbiter SHALL issue at most one regfile write per cycle and SHALL never write register 0.

Reset
REQ-027 While reset=0, asynchronously, the block SHALL force:
- reg_write=0, rd=0, reg_in=0;
- FIFO count=0 and pointers=0 (so md_ready=1);
- busy_mask=0, wait counter=0, starve_req=0, waw_err=0.
REQ-028 Reset mid-operation SHALL discard buffered results without issuing a write.
REQ-029 The first arbitration SHALL occur at the first posedge after reset deasserts.

Structure
REQ-030 A shared cpu package SHALL hold the regfile constants (REG_ADDR_W=5, NUM_REGS=32, XLEN=32) and a typedef wb_req_t {we, rd, data}.
REQ-031 The result FIFO SHALL be a separate sub-module named wb_result_fifo, parameterised by depth, exposing push/pop/count.
REQ-032 The arbitration, scoreboard and starvation logic SHALL reside in regfile_write_arbiter.

Verification
REQ-033 Reset release, then wb_we=1, rd=5, data=0xDEADBEEF at edge 1: expect reg_write=1, rd=5, reg_in=0xDEADBEEF after edge 1, and reg_write=0 after edge 2.
REQ-034 md_issue rd=7 at edge 1, then md_valid rd=7, data=0x12 at edge 3 with wb idle: expect busy_mask[7]=1 from edge 1, write after edge 4, and busy_mask[7]=0 after edge 4.
REQ-035 Two md pushes while wb_we is held with rd=3: expect md_ready=0 after the 2nd push, starve_req=1 after 4 lost cycles; dropping wb_we then yields the FIFO writes in push order.
REQ-036 Simultaneous push and pop at count=1: expect count to stay 1, order preserved, and md_ready to stay 1.
REQ-037 wb write to rd=9 while busy_mask[9]=1: expect waw_err=1 to remain set; wb write to rd=0: expect reg_write=0 and the FIFO head to pop in that slot.
REQ-038 Assert reset while count=2 and busy_mask=0x0000_0180: expect all outputs cleared immediately, with no later write of the discarded entries.
